// File: rtl/wd_fault_supervisor.sv
// wd_fault_supervisor: turns watchdog failures into an interrupt, a stretched
// system reset pulse, a saturating failure count and a sticky lockout.
module wd_fault_supervisor #(
    parameter int unsigned HOLD_CYCLES = 16,
    parameter int unsigned MAX_FAILS   = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wdfail,
    input  logic [1:0] flstat,
    input  logic       rstout,
    input  logic       ack,
    output logic       irq,
    output logic       sysrst,
    output logic       lockout,
    output logic [3:0] failcnt,
    output logic [1:0] lastcause
);

    localparam int unsigned HOLD_W  = 8;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned CAUSE_W = 2;

    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]  FAIL_LIM  = CNT_W'(MAX_FAILS);
    localparam logic [CNT_W-1:0]  CNT_SAT   = '1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ALERT   = 3'd1,
        HOLD    = 3'd2,
        RECOVER = 3'd3,
        LOCKED  = 3'd4
    } state_t;

    state_t              state;
    state_t              state_d;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [HOLD_W-1:0]   hold_cnt_d;
    logic                wdfail_q;
    logic                fail_evt;
    logic                fail_take;

    // Rising edge of the watchdog failure level; ignored once locked out.
    assign fail_evt  = wdfail & ~wdfail_q;
    assign fail_take = fail_evt && (state != LOCKED);

    // State and hold-counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            hold_cnt <= '0;
        end else begin
            state    <= state_d;
            hold_cnt <= hold_cnt_d;
        end
    end

    // Next-state and hold-counter update.
    always_comb begin
        state_d    = state;
        hold_cnt_d = hold_cnt;
        case (state)
            IDLE: begin
                if (fail_evt) state_d = ALERT;
            end
            ALERT: begin
                // failcnt already counts the failure that brought us here
                if (rstout) begin
                    if (failcnt >= FAIL_LIM) begin
                        state_d = LOCKED;
                    end else begin
                        state_d    = HOLD;
                        hold_cnt_d = HOLD_LOAD;
                    end
                end
            end
            HOLD: begin
                if (hold_cnt == '0) state_d = RECOVER;
                else                hold_cnt_d = hold_cnt - HOLD_W'(1);
            end
            RECOVER: begin
                // wait for the request to drop so a held RSTOUT cannot retrigger
                if (fail_evt)                state_d = ALERT;
                else if (!wdfail && !rstout) state_d = IDLE;
            end
            LOCKED: begin
                state_d = LOCKED;
            end
            default: begin
                state_d    = IDLE;
                hold_cnt_d = '0;
            end
        endcase
    end

    // Reset and lockout outputs decoded from the registered state only.
    always_comb begin
        sysrst  = 1'b0;
        lockout = 1'b0;
        if (state == HOLD)   sysrst = 1'b1;
        if (state == LOCKED) begin
            sysrst  = 1'b1;
            lockout = 1'b1;
        end
    end

    // Failure bookkeeping: edge detect, cause capture, count and interrupt.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdfail_q  <= 1'b0;
            irq       <= 1'b0;
            failcnt   <= '0;
            lastcause <= CAUSE_W'(0);
        end else begin
            wdfail_q <= wdfail;
            if (fail_take) begin
                lastcause <= flstat;
                if (failcnt != CNT_SAT) failcnt <= failcnt + CNT_W'(1);
            end
            // a new failure beats a simultaneous acknowledge
            if (fail_take) irq <= 1'b1;
            else if (ack)  irq <= 1'b0;
        end
    end

endmodule
